// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared encodings for the timer_counter peripheral
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } timer_state_e;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_PRESET = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;
    localparam logic [1:0] REG_RSVD   = 2'd3;

    localparam int CTRL_W       = 4;
    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_MODE_HI = 2;
    localparam int CTRL_IM      = 3;

    localparam logic [1:0] MODE_ONESHOT = 2'd0;
    localparam logic [1:0] MODE_RELOAD  = 2'd1;

endpackage

// File: rtl/timer_counter.sv
// rtl/timer_counter.sv - memory-mapped down-counter with one-shot/auto-reload modes and IRQ
module timer_counter
    import timer_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [29:0] Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ
);

    timer_state_e       state_q, state_d;
    logic [CTRL_W-1:0]  ctrl_q, ctrl_d;
    logic [CNT_W-1:0]   preset_q, preset_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               irq_flag_q, irq_flag_d;
    logic               irq_q, irq_d;

    logic [1:0]         reg_sel;
    logic [1:0]         mode;
    logic               unused_bits;

    assign reg_sel     = Addr[1:0];
    assign mode        = ctrl_q[CTRL_MODE_HI:CTRL_MODE_LO];
    assign unused_bits = ^{Addr[29:2], Din};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            ctrl_q     <= '0;
            preset_q   <= '0;
            count_q    <= '0;
            irq_flag_q <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ctrl_q     <= ctrl_d;
            preset_q   <= preset_d;
            count_q    <= count_d;
            irq_flag_q <= irq_flag_d;
            irq_q      <= irq_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ctrl_d     = ctrl_q;
        preset_d   = preset_q;
        count_d    = count_q;
        irq_flag_d = irq_flag_q;

        case (state_q)
            ST_IDLE: begin
                if (ctrl_q[CTRL_EN]) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                count_d = preset_q;
                state_d = ST_CNT;
            end
            ST_CNT: begin
                if (!ctrl_q[CTRL_EN]) begin
                    state_d = ST_IDLE;
                end else if (count_q > CNT_W'(1)) begin
                    count_d = count_q - CNT_W'(1);
                end else begin
                    count_d    = '0;
                    irq_flag_d = 1'b1;
                    state_d    = ST_INT;
                end
            end
            ST_INT: begin
                if (mode == MODE_RELOAD) begin
                    irq_flag_d = 1'b0;
                    state_d    = ST_LOAD;
                end else begin
                    ctrl_d[CTRL_EN] = 1'b0;
                    state_d         = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // CPU writes come last so a written En overrides the one-shot clear
        if (WE) begin
            case (reg_sel)
                REG_CTRL: begin
                    ctrl_d     = Din[CTRL_W-1:0];
                    irq_flag_d = 1'b0;
                end
                REG_PRESET: begin
                    preset_d   = Din[CNT_W-1:0];
                    irq_flag_d = 1'b0;
                end
                default: ;
            endcase
        end
    end

    // IM comes from the post-write CTRL so setting IM exposes a pending flag at once
    always_comb begin
        irq_d = irq_flag_q & ctrl_d[CTRL_IM];
        Dout  = '0;
        case (reg_sel)
            REG_CTRL:   Dout[CTRL_W-1:0] = ctrl_q;
            REG_PRESET: Dout[CNT_W-1:0]  = preset_q;
            REG_COUNT:  Dout[CNT_W-1:0]  = count_q;
            REG_RSVD:   Dout             = '0;
            default:    Dout             = '0;
        endcase
    end

    assign IRQ = irq_q;

endmodule
